// File: rtl/servo_ctrl_pkg.sv
// Shared types and defaults for the ball-plate servo position sequencer.
//   pos_t         : 7-bit servo position (0..127)
//   parse_state_e : packet parser states
//   HEADER_DEF    : default packet sync byte
//   CENTER_DEF    : default reset / fallback position
package servo_ctrl_pkg;

  typedef logic [6:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_GOTX = 2'd2
  } parse_state_e;

  localparam logic [7:0] HEADER_DEF = 8'hFF;
  localparam pos_t       CENTER_DEF = 7'd64;

endpackage

// File: rtl/servo_slew_axis.sv
// One servo axis: holds the driven position and moves it toward the target
// by at most MAX_STEP each time step_en_i is high.
//   clk       : system clock
//   rst_n     : synchronous active-low reset (position returns to CENTER)
//   step_en_i : one-cycle step strobe (the frame tick)
//   target_i  : requested position
//   pos_o     : registered position to the PWM driver
module servo_slew_axis
  import servo_ctrl_pkg::*;
#(
  parameter int   MAX_STEP = 4,
  parameter pos_t CENTER   = CENTER_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_en_i,
  input  pos_t target_i,
  output pos_t pos_o
);

  localparam pos_t STEP = pos_t'(MAX_STEP);

  pos_t       pos_q, pos_d;
  logic [7:0] diff;  // two's-complement target - pos
  logic [7:0] mag;   // |diff|

  always_comb begin
    diff  = {1'b0, target_i} - {1'b0, pos_q};
    mag   = diff[7] ? (~diff + 8'd1) : diff;
    pos_d = pos_q;
    if (step_en_i) begin
      if (mag <= 8'(MAX_STEP)) begin
        pos_d = target_i;
      end else if (diff[7]) begin
        pos_d = pos_q - STEP;  // cannot underflow: target lies below by more than STEP
      end else begin
        pos_d = pos_q + STEP;  // cannot overflow: target lies above by more than STEP
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= CENTER;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/servo_position_sequencer.sv
// Parses HEADER,X,Y packets from the UART into X/Y targets, generates the
// servo frame strobe, slew-limits both axes once per frame and falls back to
// centre when no valid packet has arrived for TIMEOUT_FRAMES frames.
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   rx_data_i    : received UART byte
//   rx_valid_i   : one-cycle strobe qualifying rx_data_i
//   pos_x_o      : X-axis position to PWM driver
//   pos_y_o      : Y-axis position to PWM driver
//   frame_tick_o : pulse on the last tick of each frame
//   link_ok_o    : high while packets arrive within the timeout window
//   pkt_err_o    : one-cycle pulse on a malformed packet
module servo_position_sequencer
  import servo_ctrl_pkg::*;
#(
  parameter int         FRAME_TICKS    = 360,
  parameter int         MAX_STEP       = 4,
  parameter int         TIMEOUT_FRAMES = 50,
  parameter pos_t       CENTER         = CENTER_DEF,
  parameter logic [7:0] HEADER         = HEADER_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output pos_t       pos_x_o,
  output pos_t       pos_y_o,
  output logic       frame_tick_o,
  output logic       link_ok_o,
  output logic       pkt_err_o
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  // ---------------- frame counter ----------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CW'(FRAME_TICKS - 1)) ? '0 : cnt_q + CW'(1);
    // Registered strobe: high while the counter holds its last value.
    tick_d = (cnt_d == CW'(FRAME_TICKS - 1));
  end

  // ---------------- packet parser ----------------
  parse_state_e state_q, state_d;
  pos_t         x_tmp_q, x_tmp_d;
  logic         err_q, err_d;
  logic         commit;

  always_comb begin
    state_d = state_q;
    x_tmp_d = x_tmp_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    if (rx_valid_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data_i == HEADER) state_d = ST_HDR;
        end
        ST_HDR, ST_GOTX: begin
          if (rx_data_i == HEADER) begin
            state_d = ST_HDR;          // resync on a fresh header
          end else if (rx_data_i[7]) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (state_q == ST_HDR) begin
            x_tmp_d = rx_data_i[6:0];
            state_d = ST_GOTX;
          end else begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- targets and timeout ----------------
  pos_t       tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       link_q, link_d;

  always_comb begin
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    to_cnt_d = to_cnt_q;
    link_d   = link_q;
    if (commit) begin
      // A commit outranks a timeout expiring on the same edge.
      tgt_x_d  = x_tmp_q;
      tgt_y_d  = rx_data_i[6:0];
      to_cnt_d = '0;
      link_d   = 1'b1;
    end else if (tick_q && (to_cnt_q < 8'(TIMEOUT_FRAMES))) begin
      to_cnt_d = to_cnt_q + 8'd1;
      if (to_cnt_q == 8'(TIMEOUT_FRAMES - 1)) begin
        link_d  = 1'b0;
        tgt_x_d = CENTER;
        tgt_y_d = CENTER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      state_q  <= ST_IDLE;
      x_tmp_q  <= '0;
      err_q    <= 1'b0;
      tgt_x_q  <= CENTER;
      tgt_y_q  <= CENTER;
      to_cnt_q <= '0;
      link_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      x_tmp_q  <= x_tmp_d;
      err_q    <= err_d;
      tgt_x_q  <= tgt_x_d;
      tgt_y_q  <= tgt_y_d;
      to_cnt_q <= to_cnt_d;
      link_q   <= link_d;
    end
  end

  // ---------------- slew-limited axes ----------------
  // Stepping on the tick edge sees the pre-commit target, so a packet
  // landing on the tick cycle only affects the following frame.
  servo_slew_axis #(.MAX_STEP(MAX_STEP), .CENTER(CENTER)) u_axis_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en_i(tick_q),
    .target_i (tgt_x_q),
    .pos_o    (pos_x_o)
  );

  servo_slew_axis #(.MAX_STEP(MAX_STEP), .CENTER(CENTER)) u_axis_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en_i(tick_q),
    .target_i (tgt_y_q),
    .pos_o    (pos_y_o)
  );

  assign frame_tick_o = tick_q;
  assign link_ok_o    = link_q;
  assign pkt_err_o    = err_q;

endmodule

// File: tb/tb_servo_position_sequencer.sv
// Scoreboard bench for servo_position_sequencer. The stimulus process drives
// bytes frame by frame and pushes, for every frame, the expected positions,
// link state and error-pulse count produced by a packet/frame-level model.
// A monitor pops one entry after every frame tick and compares.
module tb_servo_position_sequencer;
  import servo_ctrl_pkg::*;

  localparam int FT  = 360;
  localparam int MS  = 4;
  localparam int TO  = 50;
  localparam int CTR = 64;
  localparam int HDR = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  pos_t       pos_x, pos_y;
  logic       frame_tick, link_ok, pkt_err;

  always #5 clk = ~clk;

  servo_position_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .pos_x_o     (pos_x),
    .pos_y_o     (pos_y),
    .frame_tick_o(frame_tick),
    .link_ok_o   (link_ok),
    .pkt_err_o   (pkt_err)
  );

  typedef struct {
    int px;
    int py;
    int lk;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_px, m_py, m_tx, m_ty, m_link, m_frames, m_err;
  bit m_sync, m_committed;
  int m_data[$];

  task automatic model_reset();
    m_px = CTR; m_py = CTR; m_tx = CTR; m_ty = CTR;
    m_link = 0; m_frames = 0; m_err = 0; m_sync = 0;
    m_data.delete();
  endtask

  // Packet-level view: a header opens a packet, two 7-bit bytes close it.
  task automatic model_byte(input int b);
    m_committed = 0;
    if (b == HDR) begin
      m_sync = 1;
      m_data.delete();
    end else if (m_sync) begin
      if (b >= 128) begin
        m_err++;
        m_sync = 0;
      end else begin
        m_data.push_back(b);
        if (m_data.size() == 2) begin
          m_tx = m_data[0]; m_ty = m_data[1];
          m_frames = 0; m_link = 1; m_committed = 1;
          m_sync = 0;
        end
      end
    end
  endtask

  function automatic int slew(input int p, input int t);
    int d;
    d = t - p;
    if (d <= MS && d >= -MS) return t;
    return (d > 0) ? p + MS : p - MS;
  endfunction

  // ---------------- stimulus helpers ----------------
  int ev_c[$];
  int ev_b[$];

  task automatic send(input int c, input int b);
    ev_c.push_back(c);
    ev_b.push_back(b);
  endtask

  // Runs one frame starting in cycle 0 (inputs driven #1 after each edge).
  task automatic run_frame(input int abort_c);
    m_err = 0;
    for (int c = 0; c < FT; c++) begin
      if (c == abort_c) break;
      rx_valid = 1'b0;
      if (c == FT - 1) begin
        // Tick edge: step with the target standing before any tick-cycle byte.
        m_px = slew(m_px, m_tx);
        m_py = slew(m_py, m_ty);
        m_committed = 0;
        if (ev_c.size() > 0 && ev_c[0] == c) begin
          rx_valid = 1'b1;
          rx_data  = 8'(ev_b[0]);
          model_byte(ev_b[0]);
          void'(ev_c.pop_front());
          void'(ev_b.pop_front());
        end
        if (!m_committed && m_frames < TO) begin
          m_frames++;
          if (m_frames == TO) begin
            m_link = 0; m_tx = CTR; m_ty = CTR;
          end
        end
        exp_q.push_back('{px: m_px, py: m_py, lk: m_link, err: m_err});
      end else if (ev_c.size() > 0 && ev_c[0] == c) begin
        rx_valid = 1'b1;
        rx_data  = 8'(ev_b[0]);
        model_byte(ev_b[0]);
        void'(ev_c.pop_front());
        void'(ev_b.pop_front());
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    ev_c.delete();
    ev_b.delete();
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) run_frame(-1);
  endtask

  task automatic do_reset_and_check(input string tag);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_pos_x"}, int'(pos_x), CTR);
    check({tag, "_pos_y"}, int'(pos_y), CTR);
    check({tag, "_link_ok"}, int'(link_ok), 0);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
    check({tag, "_pkt_err"}, int'(pkt_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int rand_byte();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 3) return HDR;
    if (r < 8) return int'($urandom_range(0, 127));
    return int'($urandom_range(128, 254));
  endfunction

  // ---------------- monitor ----------------
  initial begin
    bit   pend;
    int   errs;
    exp_t e;
    pend = 0;
    errs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        errs = 0;
      end else begin
        if (pend) begin
          pend = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame_tick", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pos_x", int'(pos_x), e.px);
            check("pos_y", int'(pos_y), e.py);
            check("link_ok", int'(link_ok), e.lk);
            check("pkt_err_pulses", errs, e.err);
            $display("frame: pos_x=%0d pos_y=%0d link_ok=%0d pkt_err=%0d", pos_x, pos_y, link_ok, errs);
          end
          errs = 0;
        end
        if (pkt_err) errs++;
        if (frame_tick) pend = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    model_reset();
    do_reset_and_check("reset");

    // 1: no traffic
    idle_frames(2);

    // 2: FF,84,40 then settle
    send(10, HDR); send(20, 84); send(30, 40);
    run_frame(-1);
    idle_frames(6);

    // 3: FF,10,80 then silence through timeout and return to centre
    send(40, HDR); send(41, 10); send(42, 80);
    run_frame(-1);
    idle_frames(66);

    // 4: resync on a second header
    send(50, HDR); send(100, 30); send(150, HDR); send(200, 90); send(250, 100);
    run_frame(-1);
    idle_frames(1);

    // 5: bad data byte, then a good packet
    send(60, HDR); send(70, 30); send(80, 133);
    run_frame(-1);
    send(60, HDR); send(70, 5); send(80, 5);
    run_frame(-1);
    idle_frames(1);

    // 6: Y byte on the tick cycle
    send(100, HDR); send(200, 120); send(FT - 1, 2);
    run_frame(-1);
    idle_frames(2);

    // randomized traffic
    for (int f = 0; f < 30; f++) begin
      n = int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) send(20 + k * 60 + int'($urandom_range(0, 40)), rand_byte());
      run_frame(-1);
    end

    // 6b: reset between X and Y bytes; a lone Y byte afterwards is ignored
    send(10, HDR); send(20, 100);
    run_frame(30);
    do_reset_and_check("midpkt_reset");
    send(10, 5);
    run_frame(-1);
    idle_frames(1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
